// File: rtl/axi_rab_pkg.sv
// Shared definitions for the AXI response arbiters: BRESP/RRESP encodings,
// a constant clog2, and helpers that pull one source's field out of a
// packed per-source bus.
package axi_rab_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    // Callers zero-extend their packed bus to BUS_MAX bits and truncate the
    // returned field back to its real width. This keeps one helper usable
    // for any field width.
    localparam int BUS_MAX   = 512;
    localparam int FIELD_MAX = 64;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Field of width 'width' belonging to source 'idx' in a packed bus.
    function automatic logic [FIELD_MAX-1:0] get_field(
        input logic [BUS_MAX-1:0] bus,
        input int unsigned        idx,
        input int unsigned        width
    );
        logic [BUS_MAX-1:0]   shifted;
        logic [FIELD_MAX-1:0] mask;
        shifted = bus >> (idx * width);
        mask    = (FIELD_MAX'(1) << width) - FIELD_MAX'(1);
        return shifted[FIELD_MAX-1:0] & mask;
    endfunction

    // SLVERR and DECERR both have the top response bit set.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with its own last-grant pointer. The search starts one
// past the last winner and wraps modulo N, so a non-power-of-two N never
// produces an out-of-range index.
module rr_arbiter
    import axi_rab_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx
);

    logic [W-1:0] ptr;
    logic [W-1:0] cand;
    logic         found;

    // First requester after the pointer, scanning with wrap-around.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand = W'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Pointer moves to the winner only when the grant is actually taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= W'(N - 1);
        end else if (advance) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/axi_bresp_arb.sv
// Merges NUM_SRC AXI B channels onto one registered master-facing B channel,
// serving sources round-robin and keeping a sticky flag for error responses.
module axi_bresp_arb
    import axi_rab_pkg::*;
#(
    parameter  int NUM_SRC    = 4,
    parameter  int ID_WIDTH   = 8,
    parameter  int USER_WIDTH = 2,
    localparam int SRC_W      = clog2(NUM_SRC)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_SRC*ID_WIDTH-1:0]    in_mbid,
    input  logic [NUM_SRC*2-1:0]           in_mbresp,
    input  logic [NUM_SRC*USER_WIDTH-1:0]  in_mbuser,
    input  logic [NUM_SRC-1:0]             in_mbvalid,
    output logic [NUM_SRC-1:0]             out_mbready,
    output logic [ID_WIDTH-1:0]            out_sbid,
    output logic [1:0]                     out_sbresp,
    output logic [USER_WIDTH-1:0]          out_sbuser,
    output logic                           out_sbvalid,
    input  logic                           in_sbready,
    output logic [SRC_W-1:0]               out_src,
    output logic                           out_err,
    input  logic                           in_err_clr
);

    logic                  load_en;
    logic                  accept;
    logic [NUM_SRC-1:0]    grant;
    logic [SRC_W-1:0]      grant_idx;
    logic [BUS_MAX-1:0]    id_bus;
    logic [BUS_MAX-1:0]    resp_bus;
    logic [BUS_MAX-1:0]    user_bus;
    logic [ID_WIDTH-1:0]   sel_id;
    logic [1:0]            sel_resp;
    logic [USER_WIDTH-1:0] sel_user;

    // The output register can take a new response when empty or draining;
    // reset blocks every handshake.
    assign load_en     = ~out_sbvalid | in_sbready;
    assign accept      = load_en & (|in_mbvalid) & ~reset;
    assign out_mbready = accept ? grant : '0;

    assign id_bus   = BUS_MAX'(in_mbid);
    assign resp_bus = BUS_MAX'(in_mbresp);
    assign user_bus = BUS_MAX'(in_mbuser);
    assign sel_id   = ID_WIDTH'(get_field(id_bus, 32'(grant_idx), ID_WIDTH));
    assign sel_resp = 2'(get_field(resp_bus, 32'(grant_idx), 2));
    assign sel_user = USER_WIDTH'(get_field(user_bus, 32'(grant_idx), USER_WIDTH));

    rr_arbiter #(
        .N(NUM_SRC)
    ) u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (in_mbvalid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Output register: load on accept, empty on drain, hold while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_sbvalid <= 1'b0;
            out_sbid    <= '0;
            out_sbresp  <= '0;
            out_sbuser  <= '0;
            out_src     <= '0;
        end else if (accept) begin
            out_sbvalid <= 1'b1;
            out_sbid    <= sel_id;
            out_sbresp  <= sel_resp;
            out_sbuser  <= sel_user;
            out_src     <= grant_idx;
        end else if (load_en) begin
            out_sbvalid <= 1'b0;
        end
    end

    // Sticky error flag; a new error outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_err <= 1'b0;
        end else if (accept && resp_is_err(sel_resp)) begin
            out_err <= 1'b1;
        end else if (in_err_clr) begin
            out_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_bresp_arb.sv
// Directed bench for axi_bresp_arb: a 4-source instance for the main
// scenarios and a 3-source instance for the non-power-of-two wrap.
module tb_axi_bresp_arb;

    logic        clk;
    logic        reset;

    logic [31:0] in_mbid;
    logic [7:0]  in_mbresp;
    logic [7:0]  in_mbuser;
    logic [3:0]  in_mbvalid;
    logic [3:0]  out_mbready;
    logic [7:0]  out_sbid;
    logic [1:0]  out_sbresp;
    logic [1:0]  out_sbuser;
    logic        out_sbvalid;
    logic        in_sbready;
    logic [1:0]  out_src;
    logic        out_err;
    logic        in_err_clr;

    logic [23:0] in_mbid3;
    logic [5:0]  in_mbresp3;
    logic [5:0]  in_mbuser3;
    logic [2:0]  in_mbvalid3;
    logic [2:0]  out_mbready3;
    logic [7:0]  out_sbid3;
    logic [1:0]  out_sbresp3;
    logic [1:0]  out_sbuser3;
    logic        out_sbvalid3;
    logic        in_sbready3;
    logic [1:0]  out_src3;
    logic        out_err3;

    int checks;
    int passes;
    int grants0;
    int grants1;

    axi_bresp_arb #(.NUM_SRC(4), .ID_WIDTH(8), .USER_WIDTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_mbid     (in_mbid),
        .in_mbresp   (in_mbresp),
        .in_mbuser   (in_mbuser),
        .in_mbvalid  (in_mbvalid),
        .out_mbready (out_mbready),
        .out_sbid    (out_sbid),
        .out_sbresp  (out_sbresp),
        .out_sbuser  (out_sbuser),
        .out_sbvalid (out_sbvalid),
        .in_sbready  (in_sbready),
        .out_src     (out_src),
        .out_err     (out_err),
        .in_err_clr  (in_err_clr)
    );

    axi_bresp_arb #(.NUM_SRC(3), .ID_WIDTH(8), .USER_WIDTH(2)) dut3 (
        .clk         (clk),
        .reset       (reset),
        .in_mbid     (in_mbid3),
        .in_mbresp   (in_mbresp3),
        .in_mbuser   (in_mbuser3),
        .in_mbvalid  (in_mbvalid3),
        .out_mbready (out_mbready3),
        .out_sbid    (out_sbid3),
        .out_sbresp  (out_sbresp3),
        .out_sbuser  (out_sbuser3),
        .out_sbvalid (out_sbvalid3),
        .in_sbready  (in_sbready3),
        .out_src     (out_src3),
        .out_err     (out_err3),
        .in_err_clr  (1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, report any difference.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    // Drive the 4-source side, then let combinational outputs settle.
    task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] bids,
                                 input logic [7:0] resps, input logic sbready,
                                 input logic err_clr);
        in_mbvalid = valid;
        in_mbid    = bids;
        in_mbresp  = resps;
        in_sbready = sbready;
        in_err_clr = err_clr;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        passes  = 0;
        grants0 = 0;
        grants1 = 0;
        reset   = 1'b1;
        in_mbuser   = 8'b11_10_01_00;
        in_mbid3    = '0;
        in_mbresp3  = '0;
        in_mbuser3  = '0;
        in_mbvalid3 = '0;
        in_sbready3 = 1'b0;
        applyStimulus(4'b1111, 32'h13121110, 8'h00, 1'b1, 1'b0);
        step();
        step();

        // Reset state, with every source requesting.
        checkOutput("rst_ready",  32'(out_mbready), 0);
        checkOutput("rst_valid",  32'(out_sbvalid), 0);
        checkOutput("rst_id",     32'(out_sbid),    0);
        checkOutput("rst_src",    32'(out_src),     0);
        checkOutput("rst_err",    32'(out_err),     0);

        // All four sources valid: served 0,1,2,3 on consecutive cycles.
        reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("s1_ready", 32'(out_mbready), 32'(1 << i));
            step();
            checkOutput("s1_valid", 32'(out_sbvalid), 1);
            checkOutput("s1_id",    32'(out_sbid),    32'(8'h10 + i));
            checkOutput("s1_src",   32'(out_src),     32'(i));
            checkOutput("s1_user",  32'(out_sbuser),  32'(i));
        end

        // Fairness: sources 0 and 1 both valid alternate.
        applyStimulus(4'b0011, 32'h00002120, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step();
            checkOutput("fair_src", 32'(out_src), 32'(i % 2));
            if (out_src == 2'd0) grants0++;
            if (out_src == 2'd1) grants1++;
        end
        checkOutput("fair_cnt0", 32'(grants0), 4);
        checkOutput("fair_cnt1", 32'(grants1), 4);

        // Drain.
        applyStimulus(4'b0000, 32'h0, 8'h00, 1'b1, 1'b0);
        step();
        checkOutput("drain_valid", 32'(out_sbvalid), 0);

        // Stall: source 2 accepted, master not ready for 5 cycles.
        applyStimulus(4'b0100, 32'h00A50000, 8'h00, 1'b0, 1'b0);
        checkOutput("st_ready0", 32'(out_mbready), 32'b0100);
        step();
        checkOutput("st_valid", 32'(out_sbvalid), 1);
        applyStimulus(4'b0001, 32'h00000077, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("st_ready", 32'(out_mbready), 0);
            step();
            checkOutput("st_id",    32'(out_sbid),    32'hA5);
            checkOutput("st_src",   32'(out_src),     2);
            checkOutput("st_hold",  32'(out_sbvalid), 1);
        end
        applyStimulus(4'b0001, 32'h00000077, 8'h00, 1'b1, 1'b0);
        checkOutput("st_rel_ready", 32'(out_mbready), 32'b0001);
        step();
        checkOutput("st_next_id",  32'(out_sbid), 32'h77);
        checkOutput("st_next_src", 32'(out_src),  0);
        applyStimulus(4'b0000, 32'h0, 8'h00, 1'b1, 1'b0);
        step();
        checkOutput("st_empty",   32'(out_sbvalid), 0);
        checkOutput("st_id_held", 32'(out_sbid),    32'h77);

        // Error flag: DECERR sets, OKAY keeps, set beats clear, clear alone.
        applyStimulus(4'b1000, 32'h33000000, 8'b11_00_00_00, 1'b1, 1'b0);
        checkOutput("err_pre", 32'(out_err), 0);
        step();
        checkOutput("err_set",  32'(out_err),    1);
        checkOutput("err_resp", 32'(out_sbresp), 3);
        checkOutput("err_src",  32'(out_src),    3);
        applyStimulus(4'b0010, 32'h00004100, 8'h00, 1'b1, 1'b0);
        step();
        checkOutput("err_okay_src", 32'(out_src),    1);
        checkOutput("err_sticky",   32'(out_err),    1);
        checkOutput("err_okay",     32'(out_sbresp), 0);
        applyStimulus(4'b0100, 32'h00520000, 8'b00_10_00_00, 1'b1, 1'b1);
        step();
        checkOutput("err_setwin", 32'(out_err),    1);
        checkOutput("err_slv",    32'(out_sbresp), 2);
        applyStimulus(4'b0000, 32'h0, 8'h00, 1'b1, 1'b1);
        step();
        checkOutput("err_clr", 32'(out_err), 0);

        // Reset while holding a stalled response.
        applyStimulus(4'b0010, 32'h00006100, 8'h00, 1'b0, 1'b0);
        step();
        checkOutput("mr_valid", 32'(out_sbvalid), 1);
        checkOutput("mr_id",    32'(out_sbid),    32'h61);
        applyStimulus(4'b0000, 32'h0, 8'h00, 1'b0, 1'b0);
        step();
        reset = 1'b1;
        applyStimulus(4'b1001, 32'h73000070, 8'h00, 1'b1, 1'b0);
        checkOutput("mr_ready_in", 32'(out_mbready), 0);
        step();
        checkOutput("mr_dropped", 32'(out_sbvalid), 0);
        checkOutput("mr_ready",   32'(out_mbready), 0);
        checkOutput("mr_id_rst",  32'(out_sbid),    0);
        reset = 1'b0;
        #1;
        checkOutput("mr_tie_ready", 32'(out_mbready), 32'b0001);
        step();
        checkOutput("mr_tie_src", 32'(out_src),  0);
        checkOutput("mr_tie_id",  32'(out_sbid), 32'h70);

        // Three-source instance: wrap 0,1,2,0,1,2.
        applyStimulus(4'b0000, 32'h0, 8'h00, 1'b1, 1'b0);
        in_mbvalid3 = 3'b111;
        in_mbid3    = 24'h222120;
        in_sbready3 = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            step();
            checkOutput("n3_src", 32'(out_src3),  32'(i % 3));
            checkOutput("n3_id",  32'(out_sbid3), 32'(8'h20 + (i % 3)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
